// File: rtl/adc_fifo_pkg.sv
// Shared register map, STATUS/CTRL bit positions and FSM encoding for the
// ADC FIFO APB reader.
package adc_fifo_pkg;

  localparam logic [1:0] ADDR_DATA_LO = 2'd0;
  localparam logic [1:0] ADDR_DATA_HI = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  localparam int STATUS_EMPTY_BIT      = 0;
  localparam int STATUS_FULL_BIT       = 1;
  localparam int STATUS_HOLD_VALID_BIT = 2;
  localparam int STATUS_FULL_SEEN_BIT  = 3;
  localparam int STATUS_POP_LSB        = 16;

  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  typedef struct packed {
    logic [7:0] pop_count;
    logic       full_seen;
    logic       hold_valid;
    logic       fifo_full;
    logic       fifo_empty;
  } status_t;

  // Places the status fields at their architectural bit positions.
  function automatic logic [31:0] pack_status(input status_t s);
    logic [31:0] w;
    w = '0;
    w[STATUS_EMPTY_BIT]          = s.fifo_empty;
    w[STATUS_FULL_BIT]           = s.fifo_full;
    w[STATUS_HOLD_VALID_BIT]     = s.hold_valid;
    w[STATUS_FULL_SEEN_BIT]      = s.full_seen;
    w[STATUS_POP_LSB +: 8]       = s.pop_count;
    return w;
  endfunction

endpackage

// File: rtl/adc_fifo_apb_reader.sv
// APB3 slave that pops wide ADC samples from a show-ahead FIFO, exposing them
// as a low/high register pair plus status, control and a level interrupt.
module adc_fifo_apb_reader
  import adc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 56
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [3:0]            paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  fifo_rd_en,
  output logic                  fifo_clear,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_full,
  output logic                  irq
);

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] hold;
  logic                  hold_valid;
  logic [7:0]            pop_count;
  logic                  full_seen;
  logic                  irq_en;

  logic                  access;
  logic [1:0]            reg_sel;
  logic [31:0]           hold_hi;
  logic [31:0]           rdata_d;
  logic                  err_d;
  logic                  pop_req;
  logic                  clear_req;
  logic                  full_seen_clr;
  logic                  irq_en_wr;
  status_t               status;

  assign access  = (state == ST_IDLE) && psel && penable;
  assign reg_sel = paddr[3:2];
  assign hold_hi = 32'(hold >> 32);

  assign status.pop_count  = pop_count;
  assign status.full_seen  = full_seen;
  assign status.hold_valid = hold_valid;
  assign status.fifo_full  = fifo_full;
  assign status.fifo_empty = fifo_empty;

  // Decode of the access phase; the results are only committed on the
  // IDLE->RESP edge, so they may freely depend on live inputs here.
  always_comb begin
    rdata_d       = '0;
    err_d         = 1'b0;
    pop_req       = 1'b0;
    clear_req     = 1'b0;
    full_seen_clr = 1'b0;
    irq_en_wr     = 1'b0;
    if (pwrite) begin
      case (reg_sel)
        ADDR_DATA_LO, ADDR_DATA_HI: err_d = 1'b1;
        ADDR_STATUS:  full_seen_clr = pwdata[STATUS_FULL_SEEN_BIT];
        default: begin
          irq_en_wr = 1'b1;
          clear_req = pwdata[CTRL_CLEAR_BIT];
        end
      endcase
    end else begin
      case (reg_sel)
        ADDR_DATA_LO: begin
          if (fifo_empty) begin
            err_d = 1'b1;
          end else begin
            pop_req = 1'b1;
            rdata_d = fifo_rd_data[31:0];
          end
        end
        ADDR_DATA_HI: rdata_d = hold_hi;
        ADDR_STATUS:  rdata_d = pack_status(status);
        default:      rdata_d[CTRL_IRQ_EN_BIT] = irq_en;
      endcase
    end
  end

  // Two-state handshake: every access spends one cycle in IDLE, then one in
  // RESP with pready high and the strobes pulsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pready     <= 1'b0;
      fifo_rd_en <= 1'b0;
      fifo_clear <= 1'b0;
    end else begin
      state      <= access ? ST_RESP : ST_IDLE;
      pready     <= access;
      fifo_rd_en <= access && pop_req;
      fifo_clear <= access && clear_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prdata  <= '0;
      pslverr <= 1'b0;
    end else if (access) begin
      prdata  <= rdata_d;
      pslverr <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      pop_count  <= '0;
    end else if (access && clear_req) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      pop_count  <= '0;
    end else if (access && pop_req) begin
      hold       <= fifo_rd_data;
      hold_valid <= 1'b1;
      pop_count  <= pop_count + 8'd1;
    end
  end

  // A full FIFO in the same cycle as a clear request keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_seen <= 1'b0;
    end else if (fifo_full) begin
      full_seen <= 1'b1;
    end else if (access && (clear_req || full_seen_clr)) begin
      full_seen <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en <= 1'b0;
    end else if (access && irq_en_wr) begin
      irq_en <= pwdata[CTRL_IRQ_EN_BIT];
    end
  end

  assign irq = irq_en && !fifo_empty;

  logic unused_bits;
  assign unused_bits = ^{paddr[1:0], pwdata[31:4], pwdata[2]};

endmodule

// File: doc/adc_fifo_apb_reader.md
ADC_FIFO_APB_READER -- requirements
Module: adc_fifo_apb_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 56, the FIFO entry width (legal 33..64).
REQ-002 SHALL have port clk, input, 1, the clock.
REQ-003 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have APB3 inputs psel(1), penable(1), pwrite(1), paddr(4) and pwdata(32).
REQ-005 SHALL have APB3 outputs prdata(32), pready(1) and pslverr(1).
REQ-006 SHALL have FIFO outputs fifo_rd_en(1) and fifo_clear(1), each a one-cycle pulse.
REQ-007 SHALL have FIFO inputs fifo_rd_data(DATA_WIDTH), fifo_empty(1) and fifo_full(1); fifo_rd_data is show-ahead, valid whenever fifo_empty is 0.
REQ-008 SHALL have output irq(1), a level signal.

Function
REQ-009 SHALL decode the registers on paddr[3:2]: 0 DATA_LO (read), 1 DATA_HI (read), 2 STATUS (read/W1C), 3 CTRL (read/write); paddr[1:0] is ignored.
REQ-010 SHALL use a 2-state FSM, IDLE and RESP, with no other states.
- IDLE -> RESP when psel=1 and penable=1; all side effects, prdata and pslverr are registered on that edge.
- RESP -> IDLE unconditionally.
REQ-011 SHALL register pready: 0 in IDLE, 1 in RESP; every transfer therefore has exactly one wait state.
REQ-012 SHALL handle a DATA_LO read with fifo_empty=0 as follows:
- hold <= fifo_rd_data; hold_valid <= 1; prdata <= fifo_rd_data[31:0].
- fifo_rd_en = 1 for the RESP cycle only.
- pop_count increments by 1.
REQ-013 SHALL handle a DATA_LO read with fifo_empty=1 as: pslverr=1, prdata=0, no pop, hold unchanged.
REQ-014 SHALL return on a DATA_HI read the upper bits of hold (bits DATA_WIDTH-1 down to 32), zero-extended to 32 bits, with no pop; this returns 0 if hold_valid=0.
REQ-015 SHALL return on a STATUS read: bit0 fifo_empty, bit1 fifo_full, bit2 hold_valid, bit3 full_seen, bits[23:16] pop_count, all other bits 0.
REQ-016 SHALL set full_seen in any cycle with fifo_full=1; a STATUS write with pwdata[3]=1 clears it; set wins if both occur in the same cycle.
REQ-017 SHALL handle CTRL writes as follows:
- bit1 -> irq_en.
- bit0=1 -> fifo_clear=1 for the RESP cycle, and hold, hold_valid, pop_count and full_seen are cleared on that same edge.
- A CTRL read returns {30'b0, irq_en, 1'b0}.
REQ-018 SHALL make pop_count 8 bits wide, wrapping from 255 to 0.
REQ-019 SHALL drive pslverr=1 and prdata=0 on writes to DATA_LO or DATA_HI, with no side effect.
REQ-020 SHALL drive irq = irq_en AND NOT fifo_empty, combinationally.
REQ-021 SHALL never assert fifo_rd_en and fifo_clear in the same cycle.
REQ-022 SHALL ignore psel with penable=0, which has no effect.
REQ-023 SHALL hold prdata and pslverr stable until the next transfer's RESP.

Reset
REQ-024 SHALL, while rst_n=0, force state=IDLE and drive pready=0, pslverr=0, prdata=0, fifo_rd_en=0, fifo_clear=0, hold=0, hold_valid=0, pop_count=0, full_seen=0, irq_en=0 (hence irq=0).
REQ-025 SHALL abort a transfer interrupted by reset mid-transfer, with no pop or clear pulse after reset release.
REQ-026 SHALL reach its first pready=1 no earlier than the second access cycle after rst_n rises.

Structure
REQ-027 SHALL take register offsets, STATUS/CTRL bit positions and the FSM state encoding from shared package adc_fifo_pkg.
REQ-028 SHALL be a single module with no sub-modules; the FIFO is instantiated alongside it at the parent level.

Verification
REQ-029 SHALL cover pop: FIFO holds 0xAB_CDEF0123_4567 -> DATA_LO read returns 0x01234567 with pready low for 1 cycle and fifo_rd_en for 1 cycle; DATA_HI read then returns 0x00ABCDEF.
REQ-030 SHALL cover empty read: fifo_empty=1 -> DATA_LO read gives pslverr=1, prdata=0, no fifo_rd_en, and STATUS bit2 unchanged.
REQ-031 SHALL cover wrap: 256 pops -> STATUS[23:16]=0x00; 257 pops -> 0x01.
REQ-032 SHALL cover clear: CTRL write 0x1 -> one fifo_clear pulse; STATUS then reads 0x00000001 with the FIFO empty.
REQ-033 SHALL cover full_seen: fill 16 entries -> STATUS bit3=1 and stays 1 after 1 pop; STATUS write 0x8 with fifo_full=0 -> bit3=0.
REQ-034 SHALL cover irq and reset: irq_en=1 with the FIFO non-empty -> irq=1; rst_n pulsed during RESP -> pready, fifo_rd_en and irq are 0 the next cycle and pop_count=0.
